// File: rtl/alu_pkg.sv
// Shared constants and the issue bundle type for the ALU issue stage.
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] AluOpAdd  = 4'b0000;
  localparam logic [3:0] AluOpSub  = 4'b0001;
  localparam logic [3:0] AluOpOr   = 4'b0010;
  localparam logic [3:0] AluOpSltu = 4'b0011;
  localparam logic [3:0] AluOpXor  = 4'b0100;
  localparam logic [3:0] AluOpSll  = 4'b0101;
  localparam logic [3:0] AluOpSra  = 4'b0110;
  localparam logic [3:0] AluOpSrl  = 4'b0111;
  localparam logic [3:0] AluOpAnd  = 4'b1001;
  localparam logic [3:0] AluOpSlt  = 4'b1011;

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  // 75-bit bundle handed to the ALU
  typedef struct packed {
    logic [3:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_bundle_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready buffer. in_ready is a pure function of state, so there
// is no combinational path from out_ready back to the producer.
module alu_skid_buffer #(
  parameter int unsigned WIDTH = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, skid_q;
  logic             accept, xfer;
  logic             load_out_in, load_out_skid, load_skid;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and data-register load selects
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          load_out_in = 1'b1;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_d   = StTwo;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          state_d       = StOne;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush discards buffered entries and anything offered this cycle
    if (flush) begin
      state_d       = StEmpty;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
  end

  // Output and skid data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in) begin
        out_q <= in_data;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage for OP, OP-IMM, LUI and AUIPC, feeding the ALU
// through a registered 2-entry skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_oper,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  issue_bundle_t dec, out_bundle;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_u, shamt_imm, shamt_reg;
  logic        legal;

  assign opcode    = in_instr[6:0];
  assign rd        = in_instr[11:7];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign shamt_imm = {27'b0, in_instr[24:20]};
  // The ALU saturates large shift amounts, so register shifts must be masked here
  assign shamt_reg = {27'b0, rs2_data[4:0]};

  // Combinational decode of the incoming instruction into an issue bundle
  always_comb begin
    dec      = '0;
    dec.oper = AluOpAdd;
    dec.rd   = rd;
    legal    = 1'b1;
    unique case (opcode)
      OpcOp: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        unique case (funct3)
          3'b000: dec.oper = funct7[5] ? AluOpSub : AluOpAdd;
          3'b001: begin
            dec.oper = AluOpSll;
            dec.b    = shamt_reg;
          end
          3'b010: dec.oper = AluOpSlt;
          3'b011: dec.oper = AluOpSltu;
          3'b100: dec.oper = AluOpXor;
          3'b101: begin
            dec.oper = funct7[5] ? AluOpSra : AluOpSrl;
            dec.b    = shamt_reg;
          end
          3'b110: dec.oper = AluOpOr;
          3'b111: dec.oper = AluOpAnd;
        endcase
        if (funct7 == 7'b0100000) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if (funct7 != 7'b0000000) begin
          legal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec.a = rs1_data;
        dec.b = imm_i;
        unique case (funct3)
          3'b000: dec.oper = AluOpAdd;
          3'b001: begin
            dec.oper = AluOpSll;
            dec.b    = shamt_imm;
            legal    = (funct7 == 7'b0000000);
          end
          3'b010: dec.oper = AluOpSlt;
          3'b011: dec.oper = AluOpSltu;
          3'b100: dec.oper = AluOpXor;
          3'b101: begin
            dec.oper = funct7[5] ? AluOpSra : AluOpSrl;
            dec.b    = shamt_imm;
            legal    = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'b110: dec.oper = AluOpOr;
          3'b111: dec.oper = AluOpAnd;
        endcase
      end
      OpcLui: begin
        dec.a = '0;
        dec.b = imm_u;
      end
      OpcAuipc: begin
        dec.a = in_pc;
        dec.b = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // Illegal bundles of any kind carry a neutral ADD 0,0 to the trap logic
    if (!legal) begin
      dec.oper = AluOpAdd;
      dec.a    = '0;
      dec.b    = '0;
    end
    dec.illegal = ~legal;
    dec.we      = legal && (rd != 5'd0);
  end

  alu_skid_buffer #(
    .WIDTH($bits(issue_bundle_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_bundle)
  );

  assign out_oper    = out_bundle.oper;
  assign out_a       = out_bundle.a;
  assign out_b       = out_bundle.b;
  assign out_rd      = out_bundle.rd;
  assign out_we      = out_bundle.we;
  assign out_illegal = out_bundle.illegal;

endmodule
